// File: rtl/mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mailbox_pkg
// Description : Shared types and constants for the stream mailbox endpoint
//               and its TX-side arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mailbox_pkg;

    // Destination node ID width used across the mailbox fabric
    localparam int NODE_ID_WIDTH = 16;

    // Mailbox opcodes carried alongside each beat
    localparam logic [3:0] OPC_NOP    = 4'h0;
    localparam logic [3:0] OPC_DATA   = 4'h1;
    localparam logic [3:0] OPC_STATUS = 4'h2;
    localparam logic [3:0] OPC_IRQ    = 4'h3;
    localparam logic [3:0] OPC_ERR    = 4'h4;

    // Starvation counter width; holds limits up to 15
    localparam int MBX_STARVE_W = 4;

    // TX arbiter states: free for arbitration, or owned by one requester
    typedef enum logic {
        MBX_ARB_IDLE,
        MBX_ARB_LOCKED
    } mbx_arb_state_e;

    // Increment an index and wrap it back to zero at n
    function automatic int mbx_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbx_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : mbx_rr_picker
// Description : Combinational round-robin picker. Scans the request vector
//               starting at the base index, wrapping at the top, and returns
//               the first requester found as one-hot grant plus binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module mbx_rr_picker
    import mailbox_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_base,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int   w_base_i;
    logic w_found;

    assign w_base_i = 32'(i_base);
    assign o_any    = |i_req;

    // First pass covers base..top, second pass covers the wrapped 0..base-1
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i >= w_base_i)) begin
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
                w_found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (i < w_base_i)) begin
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mailbox_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mailbox_tx_arbiter
// Description : Packet-atomic arbiter sharing the mailbox endpoint TX port
//               between NUM_REQ requesters. Two priority classes with
//               round-robin inside each, low-class anti-starvation promotion,
//               and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mailbox_tx_arbiter
    import mailbox_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int DEST_W       = NODE_ID_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*DEST_W-1:0]    req_dest,
    input  logic [NUM_REQ*4-1:0]         req_opcode,
    input  logic [NUM_REQ-1:0]           req_prio,
    input  logic [NUM_REQ-1:0]           req_eop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [DEST_W-1:0]            out_dest,
    output logic [3:0]                   out_opcode,
    output logic                         out_prio,
    output logic                         out_eop,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    output logic                         busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    // Unpacked views of the per-requester beat fields
    logic [DATA_W-1:0] w_data_arr   [NUM_REQ];
    logic [DEST_W-1:0] w_dest_arr   [NUM_REQ];
    logic [3:0]        w_opcode_arr [NUM_REQ];

    mbx_arb_state_e     r_state;
    mbx_arb_state_e     w_state_next;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_owner;
    logic               r_owner_prio;
    logic [MBX_STARVE_W-1:0] r_starve_cnt;

    logic [NUM_REQ-1:0] w_hi_req, w_lo_req;
    logic [NUM_REQ-1:0] w_hi_grant, w_lo_grant, w_win_grant;
    logic [c_IDX_W-1:0] w_hi_idx, w_lo_idx, w_win_idx, w_sel;
    logic               w_hi_any, w_lo_any, w_pick_lo, w_starved;
    logic               w_load_en, w_load, w_grant_idle, w_load_prio;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [DEST_W-1:0]  r_out_dest;
    logic [3:0]         r_out_opcode;
    logic               r_out_prio;
    logic               r_out_eop;
    logic [c_IDX_W-1:0] r_out_src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data_arr[gi]   = req_data[gi*DATA_W +: DATA_W];
            assign w_dest_arr[gi]   = req_dest[gi*DEST_W +: DEST_W];
            assign w_opcode_arr[gi] = req_opcode[gi*4 +: 4];
        end
    endgenerate

    // Split valid requests into the two priority classes
    assign w_hi_req = req_valid & req_prio;
    assign w_lo_req = req_valid & ~req_prio;

    mbx_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_hi_picker (
        .i_req   (w_hi_req),
        .i_base  (r_rr_ptr),
        .o_grant (w_hi_grant),
        .o_idx   (w_hi_idx),
        .o_any   (w_hi_any)
    );

    mbx_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_lo_picker (
        .i_req   (w_lo_req),
        .i_base  (r_rr_ptr),
        .o_grant (w_lo_grant),
        .o_idx   (w_lo_idx),
        .o_any   (w_lo_any)
    );

    // Low class wins when it has been starved long enough or high is empty
    assign w_starved   = (r_starve_cnt == MBX_STARVE_W'(STARVE_LIMIT));
    assign w_pick_lo   = (w_starved && w_lo_any) || !w_hi_any;
    assign w_win_grant = w_pick_lo ? w_lo_grant : w_hi_grant;
    assign w_win_idx   = w_pick_lo ? w_lo_idx : w_hi_idx;

    // Output register can take a new beat when empty or draining this cycle
    assign w_load_en = !r_out_valid || out_ready;

    // Locked packets keep the priority sampled on their first beat
    assign w_load_prio = (r_state == MBX_ARB_IDLE) ? req_prio[w_sel] : r_owner_prio;

    // Next-state, requester handshake and load decision
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        w_load       = 1'b0;
        w_grant_idle = 1'b0;
        w_sel        = w_win_idx;
        case (r_state)
            MBX_ARB_IDLE: begin
                if ((|req_valid) && w_load_en) begin
                    w_load       = 1'b1;
                    w_grant_idle = 1'b1;
                    req_ready    = w_win_grant;
                    if (!req_eop[w_win_idx]) begin
                        w_state_next = MBX_ARB_LOCKED;
                    end
                end
            end
            MBX_ARB_LOCKED: begin
                w_sel              = r_owner;
                req_ready[r_owner] = w_load_en;
                if (req_valid[r_owner] && w_load_en) begin
                    w_load = 1'b1;
                    if (req_eop[r_owner]) begin
                        w_state_next = MBX_ARB_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = MBX_ARB_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MBX_ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Packet-grant bookkeeping: owner, round-robin pointer, starvation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_owner_prio <= 1'b0;
            r_starve_cnt <= '0;
        end else if (w_grant_idle) begin
            r_rr_ptr     <= c_IDX_W'(mbx_wrap_inc(32'(w_win_idx), NUM_REQ));
            r_owner      <= w_win_idx;
            r_owner_prio <= req_prio[w_win_idx];
            if (!w_pick_lo && w_lo_any) begin
                if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    // Output stage: load a beat, drain on ready, otherwise hold stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_dest   <= '0;
            r_out_opcode <= '0;
            r_out_prio   <= 1'b0;
            r_out_eop    <= 1'b0;
            r_out_src    <= '0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_data_arr[w_sel];
            r_out_dest   <= w_dest_arr[w_sel];
            r_out_opcode <= w_opcode_arr[w_sel];
            r_out_prio   <= w_load_prio;
            r_out_eop    <= req_eop[w_sel];
            r_out_src    <= w_sel;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_dest   = r_out_dest;
    assign out_opcode = r_out_opcode;
    assign out_prio   = r_out_prio;
    assign out_eop    = r_out_eop;
    assign out_src    = r_out_src;
    assign busy       = (r_state == MBX_ARB_LOCKED);

    // A stalled requester must keep its beat stable until it is accepted
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_proto_chk
            a_req_stable : assert property (
                @(posedge clk) disable iff (rst)
                (req_valid[gi] && !req_ready[gi]) |=>
                (!req_valid[gi] || ($stable(w_data_arr[gi]) && $stable(w_dest_arr[gi]) &&
                                    $stable(w_opcode_arr[gi]) && $stable(req_eop[gi])))
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/mailbox_tx_arbiter.md
Name: mailbox_tx_arbiter

Overview:
- Shares the single core-side TX interface of a stream mailbox endpoint between NUM_REQ local requesters, e.g. UART RX forwarder, status reporter, error/IRQ notifier.
- Packet-atomic: once a requester wins, it owns the endpoint until its EOP beat.
- Two priority classes, with round-robin inside each class.
- Anti-starvation promotion of the low class.
- One registered output stage feeds the endpoint's tx_valid/tx_ready port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, payload width per beat.
- DEST_W, 16, destination ID width.
- STARVE_LIMIT, 4, consecutive high-class packet grants tolerated while a low-class request waits (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept.
- req_data  in  NUM_REQ*DATA_W  packed beats; requester i at [i*DATA_W +: DATA_W].
- req_dest  in  NUM_REQ*DEST_W  packed destination IDs.
- req_opcode  in  NUM_REQ*4  packed opcodes.
- req_prio  in  NUM_REQ  1 = high class; sampled on the first beat only.
- req_eop  in  NUM_REQ  last beat of packet.
- out_valid  out  1  to endpoint tx_valid.
- out_ready  in  1  from endpoint tx_ready.
- out_data  out  DATA_W  beat payload.
- out_dest  out  DEST_W  destination ID.
- out_opcode  out  4  opcode.
- out_prio  out  1  priority.
- out_eop  out  1  EOP.
- out_src  out  $clog2(NUM_REQ)  index of the requester that produced the beat.
- busy  out  1  high while in LOCKED state.

Behaviour:
- Reset values: out_valid=0, out_data/dest/opcode/prio/eop/src=0, busy=0, req_ready=0. State=IDLE, rr_ptr=0, starve_cnt=0.
- Output register: load_en = !out_valid || out_ready.
  - While out_valid=1 && out_ready=0, all out_* hold stable.
  - Latency: an accepted request beat appears on out_* the next cycle.
- IDLE:
  - Entry condition: any req_valid && load_en.
  - Winner selection: if starve_cnt==STARVE_LIMIT and any low-class request is valid, pick the low class. Otherwise pick the high class if any high request is valid, else the low class.
  - Within the chosen class, round-robin starting from index rr_ptr and wrapping at NUM_REQ-1 to 0.
  - req_ready[w]=1 combinationally in the same cycle; the beat loads into the output register; rr_ptr <= w+1 (mod NUM_REQ).
  - If req_eop=0: go to LOCKED with owner=w and owner prio latched. If req_eop=1 (single-beat packet): stay in IDLE.
  - No load when load_en=0; req_ready stays all 0.
- LOCKED:
  - req_ready[owner]=load_en; all other req_ready=0.
  - Owner beats pass in order; out_prio = latched prio.
  - A transfer with req_eop=1 returns to IDLE.
  - Owner deasserting req_valid mid-packet is a bubble: state is held, no timeout.
- Starvation counter, updated once per packet grant in IDLE:
  - High-class grant while any low-class req_valid is asserted: starve_cnt+1, saturating at STARVE_LIMIT.
  - Low-class grant, or no low request pending at grant time: starve_cnt <= 0.
- Simultaneous events:
  - An output drain and a new load in the same cycle are legal (full throughput, 1 beat/cycle).
  - An EOP transfer and a new IDLE arbitration never happen in the same cycle: there is at least one cycle in IDLE between packets.
- Reset mid-packet: immediately back to IDLE with the output register cleared. A partial packet already emitted is not retracted; the endpoint owns that recovery.
- Requester protocol assertion: a requester holds data/dest/opcode/eop stable while req_valid=1 && req_ready=0.

Decomposition:
- mailbox_pkg gains typedef enum logic {MBX_ARB_IDLE, MBX_ARB_LOCKED} mbx_arb_state_e.
- Opcodes come from the existing OPC_* constants; DEST_W defaults to the package NODE_ID_WIDTH where that is 16.
- Sub-module mbx_rr_picker:
  - Function: combinational round-robin one-hot picker over a NUM_REQ-bit request vector with rotating base pointer.
  - Outputs: one-hot grant and binary index.
  - Instantiated twice, once for the high class and once for the low class.

Test Plan:
- Single requester, 3-beat packet (data 0xA0..0xA2, eop on beat 3), out_ready=1 → out_valid on cycles 1..3 with data A0,A1,A2, out_eop only on A2, busy high for 2 cycles, out_src=0.
- Req0 and req2 both low-class, 1-beat packets continuously valid → grants alternate 0,2,0,2, rr_ptr wraps correctly.
- Req1 high-class and req3 low-class continuously valid, STARVE_LIMIT=4 → sequence 1,1,1,1,3,1,1,1,1,3.
- Req0 mid-packet (beat 2 of 4) while req1 asserts high-class → req1 ready stays 0 until req0's eop beat transfers; req1 is granted after the next IDLE cycle.
- out_ready held 0 for 5 cycles with a beat pending → out_* stable, all req_ready=0; on release, drains at 1 beat/cycle with no gap.
- rst asserted during beat 2 of a 4-beat packet → out_valid=0 and busy=0 immediately (asynchronous); the next grant starts fresh from rr_ptr=0.
